// File: rtl/mioc_pkg.sv
// MIOC shared definitions: memory-map field encodings, map reset values and
// the IO port decode for the map register.
package mioc_pkg;

  // Low half (BA15=0) map field, MAP[1:0]
  localparam logic [1:0] LO_BOOT = 2'b00;  // SmartWriter boot ROM
  localparam logic [1:0] LO_RAM  = 2'b01;  // internal DRAM
  localparam logic [1:0] LO_EXP  = 2'b10;  // expansion RAM
  localparam logic [1:0] LO_OS7  = 2'b11;  // ColecoVision OS7 in 0000-1FFF, else DRAM

  // High half (BA15=1) map field, MAP[3:2]
  localparam logic [1:0] HI_RAM  = 2'b00;
  localparam logic [1:0] HI_EXP  = 2'b01;
  localparam logic [1:0] HI_CART = 2'b10;
  localparam logic [1:0] HI_AUX  = 2'b11;

  localparam logic [3:0] MAP_RST_COMPUTER = 4'b0000;
  localparam logic [3:0] MAP_RST_GAME     = 4'b1011;

  // Map register IO port: BA7=0, BA6=1
  localparam logic PORT_MAP_BA7 = 1'b0;
  localparam logic PORT_MAP_BA6 = 1'b1;

  typedef enum logic {
    ModeComputer = 1'b0,
    ModeGame     = 1'b1
  } mode_e;

  // IO write cycle addressed to the map register
  function automatic logic is_map_write(input logic iorq_n, input logic wr_n,
                                        input logic ba7, input logic ba6);
    return !iorq_n && !wr_n && (ba7 == PORT_MAP_BA7) && (ba6 == PORT_MAP_BA6);
  endfunction

endpackage

// File: rtl/mioc_reset_ctl.sv
// Reset control: combines the two board resets, synchronises their release
// and keeps the computer/game mode flop.
module mioc_reset_ctl
  import mioc_pkg::*;
(
  input  logic  clk_i,
  input  logic  pbrst_ni,
  input  logic  cvrst_ni,
  output logic  rst_n_o,
  output logic  sys_rst_n_o,
  output logic  net_rst_n_o,
  output mode_e mode_o
);

  logic       rst_n;
  logic [1:0] sys_sync_q;
  logic [1:0] net_sync_q;
  mode_e      mode_q;

  assign rst_n = pbrst_ni & cvrst_ni;

  // System reset: asserts at once, releases on the second clock after both inputs rise
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sys_sync_q <= 2'b00;
    end else begin
      sys_sync_q <= {sys_sync_q[0], 1'b1};
    end
  end

  // AdamNET reset follows the computer reset alone
  always_ff @(posedge clk_i or negedge pbrst_ni) begin
    if (!pbrst_ni) begin
      net_sync_q <= 2'b00;
    end else begin
      net_sync_q <= {net_sync_q[0], 1'b1};
    end
  end

  // Mode set/reset flop; computer reset has priority so both-low is well defined
  always_ff @(posedge clk_i or negedge pbrst_ni or negedge cvrst_ni) begin
    if (!pbrst_ni) begin
      mode_q <= ModeComputer;
    end else if (!cvrst_ni) begin
      mode_q <= ModeGame;
    end else begin
      mode_q <= mode_q;
    end
  end

  assign rst_n_o     = rst_n;
  assign sys_rst_n_o = sys_sync_q[1];
  assign net_rst_n_o = net_sync_q[1];
  assign mode_o      = mode_q;

endmodule

// File: rtl/mioc_top.sv
// MIOC memory/IO controller: map register, memory decode, DRAM strobes and
// Z80 bus arbitration for the 6801.
module mioc_top
  import mioc_pkg::*;
(
  input  logic B_PHI,
  input  logic PBRST_N,
  input  logic N_CVRST,
  input  logic BA15,
  input  logic BA14,
  input  logic BA13,
  input  logic BA7,
  input  logic BA6,
  input  logic BD0,
  input  logic BD1,
  input  logic BD2,
  input  logic BD3,
  input  logic N_BWR,
  input  logic BRD_N,
  input  logic BMREQ_N,
  input  logic IORQ_N,
  input  logic BRFSH_N,
  input  logic BM1_N,
  input  logic WAIT_N,
  input  logic BUSAK_N,
  input  logic DMA_N,
  input  logic OS3_N,
  output logic RST_N,
  output logic CPRST_N,
  output logic NETRST_N,
  output logic BUSRQ_N,
  output logic IS3_N,
  output logic ADDRBUFEN_N,
  output logic BOOTROMCS_N,
  output logic AUXROMCS_N,
  output logic EN245_N,
  output logic AUXDECODE1_N,
  output logic RAS_N,
  output logic CAS1_N,
  output logic CAS2_N,
  output logic MUX,
  output logic RA7,
  output logic SPINDIS_N
);

  logic       rst_n;
  logic       sys_rst_n;
  logic       net_rst_n;
  mode_e      mode;
  logic [3:0] map_q;
  logic       mem_cycle;
  logic       refresh;
  logic       ram_hit;
  logic       sel_boot;
  logic       sel_aux;
  logic       sel_cv;
  logic       sel_exp;
  logic       mux_q;
  logic       cas_q;
  logic       busrq_q;
  logic       is3_q;
  logic       unused_inputs;

  mioc_reset_ctl u_reset_ctl (
    .clk_i       (B_PHI),
    .pbrst_ni    (PBRST_N),
    .cvrst_ni    (N_CVRST),
    .rst_n_o     (rst_n),
    .sys_rst_n_o (sys_rst_n),
    .net_rst_n_o (net_rst_n),
    .mode_o      (mode)
  );

  // Map register: reset value tracks whichever reset is active, computer first
  always_ff @(posedge B_PHI or negedge PBRST_N or negedge N_CVRST) begin
    if (!PBRST_N) begin
      map_q <= MAP_RST_COMPUTER;
    end else if (!N_CVRST) begin
      map_q <= MAP_RST_GAME;
    end else if (is_map_write(IORQ_N, N_BWR, BA7, BA6)) begin
      map_q <= {BD3, BD2, BD1, BD0};
    end
  end

  assign mem_cycle = rst_n & !BMREQ_N & BRFSH_N;
  assign refresh   = rst_n & !BMREQ_N & !BRFSH_N;

  // Memory decode from the current map field of the addressed half
  always_comb begin
    sel_boot = 1'b0;
    sel_aux  = 1'b0;
    sel_cv   = 1'b0;
    sel_exp  = 1'b0;
    ram_hit  = 1'b0;
    if (mem_cycle) begin
      if (!BA15) begin
        unique case (map_q[1:0])
          LO_BOOT: sel_boot = 1'b1;
          LO_RAM:  ram_hit  = 1'b1;
          LO_EXP:  sel_exp  = 1'b1;
          LO_OS7: begin
            if (!BA14 && !BA13) sel_cv  = 1'b1;
            else                ram_hit = 1'b1;
          end
          default: ;
        endcase
      end else begin
        unique case (map_q[3:2])
          HI_RAM:  ram_hit = 1'b1;
          HI_EXP:  sel_exp = 1'b1;
          HI_CART: sel_cv  = 1'b1;
          HI_AUX:  sel_aux = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // DRAM sequencer: MUX on the first edge of a RAM access, CAS on the next;
  // both drop as soon as the memory request ends
  always_ff @(posedge B_PHI or negedge rst_n or posedge BMREQ_N) begin
    if (!rst_n) begin
      mux_q <= 1'b0;
      cas_q <= 1'b0;
    end else if (BMREQ_N) begin
      mux_q <= 1'b0;
      cas_q <= 1'b0;
    end else begin
      mux_q <= mux_q | ram_hit;
      cas_q <= cas_q | (mux_q & ram_hit);
    end
  end

  // Bus arbitration: request follows OS3_N, grant follows request plus acknowledge
  always_ff @(posedge B_PHI or negedge rst_n) begin
    if (!rst_n) begin
      busrq_q <= 1'b0;
      is3_q   <= 1'b0;
    end else begin
      busrq_q <= !OS3_N;
      is3_q   <= busrq_q & !BUSAK_N;
    end
  end

  assign RST_N        = sys_rst_n;
  assign CPRST_N      = sys_rst_n;
  assign NETRST_N     = net_rst_n;
  assign SPINDIS_N    = (mode == ModeGame);

  assign BOOTROMCS_N  = !sel_boot;
  assign AUXROMCS_N   = !sel_aux;
  assign EN245_N      = !sel_cv;
  assign AUXDECODE1_N = !sel_exp;

  assign RAS_N        = !(ram_hit | refresh);
  assign MUX          = mux_q;
  assign CAS1_N       = !(cas_q & !BA15);
  assign CAS2_N       = !(cas_q & BA15);
  assign RA7          = mux_q ? BA14 : BA7;

  assign BUSRQ_N      = !busrq_q;
  assign IS3_N        = !is3_q;
  // Z80 address buffers off while the 6801 owns the bus; on during reset
  assign ADDRBUFEN_N  = rst_n & (is3_q | !DMA_N);

  // Cycle qualifiers carried on the board but not needed by this decode
  assign unused_inputs = ^{WAIT_N, BM1_N, BRD_N};

endmodule

// File: tb/tb_mioc_top.sv
// Directed plus randomized bench for mioc_top with a behavioural decode model.
module tb_mioc_top;

  logic B_PHI;
  logic PBRST_N, N_CVRST;
  logic BA15, BA14, BA13, BA7, BA6;
  logic BD0, BD1, BD2, BD3;
  logic N_BWR, BRD_N, BMREQ_N, IORQ_N, BRFSH_N, BM1_N, WAIT_N;
  logic BUSAK_N, DMA_N, OS3_N;
  logic RST_N, CPRST_N, NETRST_N, BUSRQ_N, IS3_N, ADDRBUFEN_N;
  logic BOOTROMCS_N, AUXROMCS_N, EN245_N, AUXDECODE1_N;
  logic RAS_N, CAS1_N, CAS2_N, MUX, RA7, SPINDIS_N;

  int total = 0;
  int bad   = 0;
  logic [3:0] model_map;

  mioc_top dut (
    .B_PHI(B_PHI), .PBRST_N(PBRST_N), .N_CVRST(N_CVRST),
    .BA15(BA15), .BA14(BA14), .BA13(BA13), .BA7(BA7), .BA6(BA6),
    .BD0(BD0), .BD1(BD1), .BD2(BD2), .BD3(BD3),
    .N_BWR(N_BWR), .BRD_N(BRD_N), .BMREQ_N(BMREQ_N), .IORQ_N(IORQ_N),
    .BRFSH_N(BRFSH_N), .BM1_N(BM1_N), .WAIT_N(WAIT_N),
    .BUSAK_N(BUSAK_N), .DMA_N(DMA_N), .OS3_N(OS3_N),
    .RST_N(RST_N), .CPRST_N(CPRST_N), .NETRST_N(NETRST_N),
    .BUSRQ_N(BUSRQ_N), .IS3_N(IS3_N), .ADDRBUFEN_N(ADDRBUFEN_N),
    .BOOTROMCS_N(BOOTROMCS_N), .AUXROMCS_N(AUXROMCS_N), .EN245_N(EN245_N),
    .AUXDECODE1_N(AUXDECODE1_N), .RAS_N(RAS_N), .CAS1_N(CAS1_N), .CAS2_N(CAS2_N),
    .MUX(MUX), .RA7(RA7), .SPINDIS_N(SPINDIS_N)
  );

  initial B_PHI = 1'b0;
  always #140 B_PHI = ~B_PHI;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic edge_wait();
    @(posedge B_PHI);
    #20;
  endtask

  // Expected {BOOTROMCS_N, AUXROMCS_N, EN245_N, AUXDECODE1_N, RAS_N}
  // target: 0 boot, 1 dram, 2 expansion, 3 coleco decode, 4 aux rom
  function automatic int model_target(input logic [3:0] m, input logic a15,
                                      input logic a14, input logic a13);
    int field;
    field = a15 ? int'(m) / 4 : int'(m) % 4;
    if (a15) return field + 1;
    if (field == 3) return (a14 || a13) ? 1 : 3;
    return field;
  endfunction

  function automatic logic [4:0] model_sel(input int tgt);
    case (tgt)
      0: return 5'b01111;
      1: return 5'b11110;
      2: return 5'b11101;
      3: return 5'b11011;
      default: return 5'b10111;
    endcase
  endfunction

  function automatic logic [4:0] obs_sel();
    return {BOOTROMCS_N, AUXROMCS_N, EN245_N, AUXDECODE1_N, RAS_N};
  endfunction

  task automatic map_write(input logic [3:0] v);
    edge_wait();
    IORQ_N = 1'b0; N_BWR = 1'b0; BA7 = 1'b0; BA6 = 1'b1;
    {BD3, BD2, BD1, BD0} = v;
    edge_wait();
    IORQ_N = 1'b1; N_BWR = 1'b1; BA6 = 1'b0;
    model_map = v;
  endtask

  // One memory read with full decode and, for DRAM, the strobe sequence
  task automatic mem_read(input string tag, input logic a15, input logic a14,
                          input logic a13, input logic a7);
    int tgt;
    BA15 = a15; BA14 = a14; BA13 = a13; BA7 = a7;
    BRFSH_N = 1'b1; BMREQ_N = 1'b0;
    #1;
    tgt = model_target(model_map, a15, a14, a13);
    chk5({tag, "_sel"}, obs_sel(), model_sel(tgt));
    chk1({tag, "_ra7row"}, RA7, a7);
    if (tgt == 1) begin
      edge_wait();
      chk1({tag, "_mux"}, MUX, 1'b1);
      chk1({tag, "_ra7col"}, RA7, a14);
      edge_wait();
      chk5({tag, "_cas"}, {3'b000, CAS1_N, CAS2_N}, {3'b000, a15 ? 2'b10 : 2'b01});
    end
    BMREQ_N = 1'b1;
    #1;
    chk5({tag, "_idle"}, {MUX, CAS1_N, CAS2_N, RAS_N, BOOTROMCS_N}, 5'b01111);
  endtask

  initial begin
    PBRST_N = 1; N_CVRST = 1;
    {BA15, BA14, BA13, BA7, BA6} = '0;
    {BD3, BD2, BD1, BD0} = '0;
    N_BWR = 1; BRD_N = 1; BMREQ_N = 1; IORQ_N = 1; BRFSH_N = 1; BM1_N = 1; WAIT_N = 1;
    BUSAK_N = 1; DMA_N = 1; OS3_N = 1;
    model_map = 4'b0000;

    // Both resets low together, with a memory request pending
    #50;
    PBRST_N = 0; N_CVRST = 0;
    BMREQ_N = 0; BA15 = 0;
    #1000;
    chk1("both_rst", RST_N, 1'b0);
    chk1("both_cprst", CPRST_N, 1'b0);
    chk1("both_net", NETRST_N, 1'b0);
    chk5("both_sel", obs_sel(), 5'b11111);
    chk5("both_arb", {1'b0, BUSRQ_N, IS3_N, ADDRBUFEN_N, MUX}, 5'b01100);
    BMREQ_N = 1;
    edge_wait();
    PBRST_N = 1; N_CVRST = 1;
    edge_wait();
    chk1("both_rst_e1", RST_N, 1'b0);
    edge_wait();
    chk1("both_rst_e2", RST_N, 1'b1);
    chk1("both_net_e2", NETRST_N, 1'b1);
    chk1("both_spindis", SPINDIS_N, 1'b0);
    model_map = 4'b0000;
    mem_read("both_lo", 1'b0, 1'b0, 1'b0, 1'b0);

    // Game reset only
    N_CVRST = 0;
    #1;
    chk1("game_rst", RST_N, 1'b0);
    chk1("game_net", NETRST_N, 1'b1);
    #1000;
    edge_wait();
    N_CVRST = 1;
    edge_wait();
    chk1("game_rst_e1", CPRST_N, 1'b0);
    edge_wait();
    chk1("game_rst_e2", RST_N, 1'b1);
    chk1("game_spindis", SPINDIS_N, 1'b1);
    model_map = 4'b1011;
    mem_read("game_os7", 1'b0, 1'b0, 1'b0, 1'b1);
    mem_read("game_loram", 1'b0, 1'b1, 1'b0, 1'b0);
    mem_read("game_cart", 1'b1, 1'b0, 1'b1, 1'b0);

    // Computer reset
    PBRST_N = 0;
    #1;
    chk1("comp_rst", RST_N, 1'b0);
    chk1("comp_net", NETRST_N, 1'b0);
    chk1("comp_spindis", SPINDIS_N, 1'b0);
    #1000;
    edge_wait();
    PBRST_N = 1;
    edge_wait();
    chk5("comp_e1", {3'b000, RST_N, NETRST_N}, 5'b00000);
    edge_wait();
    chk5("comp_e2", {3'b000, RST_N, NETRST_N}, 5'b00011);
    model_map = 4'b0000;
    mem_read("comp_boot", 1'b0, 1'b1, 1'b1, 1'b0);

    // Map write then low-half DRAM access
    map_write(4'b0001);
    mem_read("w1_lo", 1'b0, 1'b1, 1'b0, 1'b1);
    mem_read("w1_hi", 1'b1, 1'b0, 1'b0, 1'b0);

    // Refresh is RAS-only
    BMREQ_N = 0; BRFSH_N = 0; BA15 = 0;
    #1;
    chk5("rfsh_sel", obs_sel(), 5'b11110);
    edge_wait();
    edge_wait();
    chk5("rfsh_strobe", {2'b00, MUX, CAS1_N, CAS2_N}, 5'b00011);
    BMREQ_N = 1; BRFSH_N = 1;

    // Bus arbitration handshake
    edge_wait();
    OS3_N = 0;
    edge_wait();
    chk5("arb_req", {2'b00, BUSRQ_N, IS3_N, ADDRBUFEN_N}, 5'b00010);
    BUSAK_N = 0;
    edge_wait();
    chk5("arb_grant", {2'b00, BUSRQ_N, IS3_N, ADDRBUFEN_N}, 5'b00001);
    OS3_N = 1;
    edge_wait();
    chk5("arb_rel1", {2'b00, BUSRQ_N, IS3_N, ADDRBUFEN_N}, 5'b00101);
    BUSAK_N = 1;
    edge_wait();
    chk5("arb_rel2", {2'b00, BUSRQ_N, IS3_N, ADDRBUFEN_N}, 5'b00110);
    DMA_N = 0;
    #1;
    chk1("arb_dma", ADDRBUFEN_N, 1'b1);
    DMA_N = 1;

    // Randomized map values and addresses against the model
    for (int i = 0; i < 12; i++) begin
      map_write(4'($urandom_range(15)));
      for (int j = 0; j < 3; j++) begin
        mem_read($sformatf("rnd%0d_%0d", i, j), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
      end
    end

    // Reset in the middle of a DRAM access aborts it and reloads the map
    map_write(4'b0001);
    BA15 = 0; BA14 = 1; BRFSH_N = 1; BMREQ_N = 0;
    edge_wait();
    edge_wait();
    chk5("abort_pre", {3'b000, MUX, CAS1_N}, 5'b00010);
    PBRST_N = 0;
    #1;
    chk5("abort_now", {MUX, CAS1_N, RAS_N, BOOTROMCS_N, RST_N}, 5'b01110);
    BMREQ_N = 1;
    edge_wait();
    PBRST_N = 1;
    edge_wait();
    edge_wait();
    chk1("abort_rst", RST_N, 1'b1);
    model_map = 4'b0000;
    mem_read("abort_map", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
